// File: rtl/pulse_gen_pkg.sv
// Shared types for the programmable pulse generator:
// run mode, config bundle and the config legality check.
package pulse_gen_pkg;

  localparam int CFG_W = 16;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] width;
    mode_e            mode;
  } cfg_t;

  // Fields are zero-extended, so the check holds for any narrower counter.
  function automatic logic cfg_legal(cfg_t c);
    return (c.period >= CFG_W'(2))
        && (c.width != '0)
        && (c.width < c.period);
  endfunction

endpackage

// File: rtl/pulse_cfg_shadow.sv
// Config intake: validates offers, holds one pending config
// and strobes o_apply at the counter boundary or while idle.
module pulse_cfg_shadow
  import pulse_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  cfg_t i_cfg,
  input  logic i_tc,
  input  logic i_idle,
  output logic o_ready,
  output logic o_err,
  output logic o_apply,
  output cfg_t o_cfg
);

  logic r_full;
  logic r_err;
  cfg_t r_cfg;

  logic w_hs;
  logic w_legal;
  logic w_take;
  logic w_apply_sh;
  logic w_apply_dir;

  assign w_hs    = i_valid & ~r_full;
  assign w_legal = cfg_legal(i_cfg);
  assign w_take  = w_hs & w_legal;

  assign w_apply_sh  = r_full & (i_tc | i_idle);
  // An offer landing on the boundary bypasses the shadow entirely.
  assign w_apply_dir = w_take & i_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_err  <= 1'b0;
      r_cfg  <= '0;
    end else begin
      r_err <= w_hs & ~w_legal;
      if (w_apply_sh) begin
        r_full <= 1'b0;
      end else if (w_take & ~i_tc) begin
        r_full <= 1'b1;
        r_cfg  <= i_cfg;
      end
    end
  end

  assign o_ready = ~r_full;
  assign o_err   = r_err;
  assign o_apply = w_apply_sh | w_apply_dir;
  assign o_cfg   = r_full ? r_cfg : i_cfg;

endmodule

// File: rtl/prog_pulse_gen.sv
// Programmable modulo-P pulse generator: q runs 0..P-1,
// pulse for the last W counts, continuous or one-shot runs.
module prog_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 3,
  parameter int DEF_WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic             cfg_oneshot,
  output logic             cfg_err,
  output logic [CNT_W-1:0] q,
  output logic             pulse,
  output logic             tc,
  output logic             busy
);

  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_width;
  mode_e            r_mode;
  logic             r_busy;

  cfg_t  w_in_cfg;
  cfg_t  w_new_cfg;
  logic  w_apply;
  logic  w_tc;
  logic  w_pulse;
  mode_e w_next_mode;

  assign w_in_cfg.period = CFG_W'(cfg_period);
  assign w_in_cfg.width  = CFG_W'(cfg_width);
  assign w_in_cfg.mode   = cfg_oneshot ? MODE_ONESHOT : MODE_CONT;

  assign w_tc = en & r_busy
              & (r_q == r_period - CNT_W'(1));
  assign w_pulse = en & r_busy
                 & (r_q >= r_period - r_width);

  pulse_cfg_shadow u_shadow (
    .clk     (clk),
    .rst     (rst),
    .i_valid (cfg_valid),
    .i_cfg   (w_in_cfg),
    .i_tc    (w_tc),
    .i_idle  (~r_busy),
    .o_ready (cfg_ready),
    .o_err   (cfg_err),
    .o_apply (w_apply),
    .o_cfg   (w_new_cfg)
  );

  assign w_next_mode = w_apply ? w_new_cfg.mode : r_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      r_period <= CNT_W'(DEF_PERIOD);
      r_width  <= CNT_W'(DEF_WIDTH);
      r_mode   <= MODE_CONT;
      r_busy   <= 1'b1;
    end else begin
      if (w_apply) begin
        r_period <= w_new_cfg.period[CNT_W-1:0];
        r_width  <= w_new_cfg.width[CNT_W-1:0];
        r_mode   <= w_new_cfg.mode;
      end
      if (r_busy & en)
        r_q <= w_tc ? '0 : r_q + CNT_W'(1);
      // Idle only ends by start or by switching to continuous.
      if (w_tc)
        r_busy <= (w_next_mode == MODE_CONT);
      else if (!r_busy)
        r_busy <= (w_next_mode == MODE_CONT) | start;
    end
  end

  assign q     = r_q;
  assign pulse = w_pulse;
  assign tc    = w_tc;
  assign busy  = r_busy;

endmodule

// File: tb/tb_prog_pulse_gen.sv
// Scoreboard bench for prog_pulse_gen: a period/width/mode
// reference model predicts each cycle, a monitor compares.
module tb_prog_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_period = '0;
  logic [7:0] cfg_width = '0;
  logic       cfg_oneshot = 1'b0;
  logic       cfg_err;
  logic [7:0] q;
  logic       pulse;
  logic       tc;
  logic       busy;

  prog_pulse_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_width   (cfg_width),
    .cfg_oneshot (cfg_oneshot),
    .cfg_err     (cfg_err),
    .q           (q),
    .pulse       (pulse),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit pulse;
    bit tc;
    bit busy;
    bit ready;
    bit err;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  // Reference state: active period/width/mode, pending config.
  bit mvalid = 0;
  int mq, mP, mW;
  bit mOS, mbusy, mfull, merr;
  int sP, sW;
  bit sOS;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("q", 32'(q), e.q);
      chk("pulse", 32'(pulse), 32'(e.pulse));
      chk("tc", 32'(tc), 32'(e.tc));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
      chk("cfg_err", 32'(cfg_err), 32'(e.err));
    end
  end

  task automatic step(input bit r, input bit e, input bit s,
                      input bit v, input int p, input int w,
                      input bit os);
    exp_t x;
    bit tcv, hs, legal;
    int nP, nW;
    bit nOS;
    @(posedge clk);
    #1;
    rst = r; en = e; start = s; cfg_valid = v;
    cfg_period = p[7:0]; cfg_width = w[7:0]; cfg_oneshot = os;
    tcv = e && mbusy && (mq == mP - 1);
    if (mvalid) begin
      x.q = mq;
      x.tc = tcv;
      x.pulse = e && mbusy && (mq >= mP - mW);
      x.busy = mbusy;
      x.ready = !mfull;
      x.err = merr;
      sb.push_back(x);
    end
    if (r) begin
      mvalid = 1; mq = 0; mP = 3; mW = 1; mOS = 0;
      mbusy = 1; mfull = 0; merr = 0;
    end else begin
      hs = v && !mfull;
      legal = (p >= 2) && (w >= 1) && (w < p);
      merr = hs && !legal;
      nP = mP; nW = mW; nOS = mOS;
      if (mfull && (tcv || !mbusy)) begin
        nP = sP; nW = sW; nOS = sOS; mfull = 0;
      end else if (hs && legal && tcv) begin
        nP = p; nW = w; nOS = os;
      end else if (hs && legal) begin
        sP = p; sW = w; sOS = os; mfull = 1;
      end
      if (mbusy && e) mq = tcv ? 0 : mq + 1;
      if (tcv) mbusy = !nOS;
      else if (!mbusy) mbusy = !nOS || s;
      mP = nP; mW = nW; mOS = nOS;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(9);
    step(0, 1, 0, 1, 5, 2, 0);
    idle(12);
    step(0, 1, 0, 1, 4, 4, 0);
    idle(4);
    step(0, 1, 0, 1, 1, 1, 0);
    idle(4);
    step(0, 1, 0, 1, 4, 1, 1);
    idle(8);
    step(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
    idle(6);
    step(0, 1, 0, 1, 3, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 1, 6, 3, 0);
    step(0, 1, 0, 1, 7, 2, 1);
    idle(3);
    step(1, 1, 0, 1, 7, 2, 1);
    idle(5);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9),
           $urandom_range(0, 9),
           1'($urandom_range(0, 1)));
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
